uart_rxr: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rxr.sv | 135 +++++++++++++
 tb/tb_uart_rxr.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and receiver.
// Holds the frame geometry, the default baud divisor and the receiver state encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// RstVal sets the flop value during reset so an idle line does not look active.
module sync_2ff #(
    parameter logic RstVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RstVal;
            sync_q <= RstVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rxr.sv
// 8N1 UART receiver: oversamples the line, centre-samples each bit and emits the byte
// with a one-cycle valid pulse, or a one-cycle framing-error pulse on a low stop bit.
module uart_rxr
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_dataline,
    output logic [DATA_BITS-1:0] o_byte,
    output logic                 o_data_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW     = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    logic rx;

    sync_2ff #(
        .RstVal (1'b1)
    ) u_sync (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .d_i    (i_dataline),
        .q_o    (rx)
    );

    uart_state_e          state_q, state_d;
    logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CntW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                if (!rx) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (clk_cnt_q == CntHalf) begin
                    clk_cnt_d = '0;
                    if (!rx) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (clk_cnt_q == CntLast) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx;
                    if (bit_idx_q == IdxLast) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
            end
            StStop: begin
                // Leaving mid-stop-bit lets a following start edge be caught with no idle gap.
                if (clk_cnt_q == CntLast) begin
                    clk_cnt_d = '0;
                    if (rx) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                // A line held low must rise before a new start edge can be recognised.
                clk_cnt_d = '0;
                if (rx) begin
                    state_d = StIdle;
                end
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = StIdle;
            end
        endcase
    end

    assign o_byte       = byte_q;
    assign o_data_valid = valid_q;
    assign o_frame_err  = ferr_q;
    assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rxr.sv
// Scoreboard bench for uart_rxr: a behavioural 8N1 transmitter drives three receivers
// (10, 4 and 17 clocks per bit); monitors pop expected bytes on every valid pulse.
module tb_uart_rxr;

    logic       clk;
    logic       rst_n;
    logic       line10, line4, line17;
    logic [7:0] byte10, byte4, byte17;
    logic       valid10, valid4, valid17;
    logic       ferr10, ferr4, ferr17;
    logic       busy10, busy4, busy17;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ferr_cnt10 = 0;
    int ferr_cnt_other = 0;

    logic [7:0] exp10[$];
    logic [7:0] exp4[$];
    logic [7:0] exp17[$];
    int         valid_cyc10[$];

    uart_rxr #(.CLKS_PER_BIT(10)) dut10 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_dataline   (line10),
        .o_byte       (byte10),
        .o_data_valid (valid10),
        .o_frame_err  (ferr10),
        .o_busy       (busy10)
    );

    uart_rxr #(.CLKS_PER_BIT(4)) dut4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_dataline   (line4),
        .o_byte       (byte4),
        .o_data_valid (valid4),
        .o_frame_err  (ferr4),
        .o_busy       (busy4)
    );

    uart_rxr #(.CLKS_PER_BIT(17)) dut17 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_dataline   (line17),
        .o_byte       (byte17),
        .o_data_valid (valid17),
        .o_frame_err  (ferr17),
        .o_busy       (busy17)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid10 || ferr10) begin
            total++;
            if (valid10 && ferr10) begin
                bad++;
                $display("FAIL pulse_exclusive10 got valid=1 ferr=1 exp at most one high");
            end
        end
        if (ferr10) ferr_cnt10++;
        if (ferr4 || ferr17) ferr_cnt_other++;
        if (valid10) begin
            valid_cyc10.push_back(cyc);
            total++;
            if (exp10.size() == 0) begin
                bad++;
                $display("FAIL byte10 got %h exp no pulse", byte10);
            end else begin
                logic [7:0] e;
                e = exp10.pop_front();
                if (byte10 !== e) begin
                    bad++;
                    $display("FAIL byte10 got %h exp %h", byte10, e);
                end
            end
        end
        if (valid4) begin
            total++;
            if (exp4.size() == 0) begin
                bad++;
                $display("FAIL byte4 got %h exp no pulse", byte4);
            end else begin
                logic [7:0] e;
                e = exp4.pop_front();
                if (byte4 !== e) begin
                    bad++;
                    $display("FAIL byte4 got %h exp %h", byte4, e);
                end
            end
        end
        if (valid17) begin
            total++;
            if (exp17.size() == 0) begin
                bad++;
                $display("FAIL byte17 got %h exp no pulse", byte17);
            end else begin
                logic [7:0] e;
                e = exp17.pop_front();
                if (byte17 !== e) begin
                    bad++;
                    $display("FAIL byte17 got %h exp %h", byte17, e);
                end
            end
        end
    end

    // All stimulus tasks start and end #1 after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 4) line4 = v;
        else if (which == 17) line17 = v;
        else line10 = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        int         cpb;
        cpb = (which == 4) ? 4 : ((which == 17) ? 17 : 10);
        f   = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_line(which, f[i]);
            tick(cpb);
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp10.size() + exp4.size() + exp17.size()) != 0 && n < limit) begin
            tick(1);
            n++;
        end
        total++;
        if ((exp10.size() + exp4.size() + exp17.size()) != 0) begin
            bad++;
            $display("FAIL %s got %0d bytes pending exp 0 after %0d cycles", name,
                     exp10.size() + exp4.size() + exp17.size(), limit);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        line10 = 1'b1;
        line4  = 1'b1;
        line17 = 1'b1;
        #2;
        total += 4;
        if (byte10 !== 8'h00) begin bad++; $display("FAIL rst_byte got %h exp 00", byte10); end
        if (valid10 !== 1'b0) begin bad++; $display("FAIL rst_valid got %b exp 0", valid10); end
        if (ferr10 !== 1'b0) begin bad++; $display("FAIL rst_ferr got %b exp 0", ferr10); end
        if (busy10 !== 1'b0) begin bad++; $display("FAIL rst_busy got %b exp 0", busy10); end
        @(posedge clk);
        #1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_loopback();
        int start;
        valid_cyc10.delete();
        start = cyc;
        exp10.push_back(8'h55);
        send_frame(10, 8'h55, 1'b1);
        tick(20);
        wait_drain("loopback_drain", 50);
        total += 2;
        if (valid_cyc10.size() != 1) begin
            bad++;
            $display("FAIL loopback_pulses got %0d exp 1", valid_cyc10.size());
        end else if (valid_cyc10[0] - start < 96 || valid_cyc10[0] - start > 100) begin
            bad++;
            $display("FAIL loopback_latency got %0d exp 96..100", valid_cyc10[0] - start);
        end
        if (ferr_cnt10 != 0) begin
            bad++;
            $display("FAIL loopback_ferr got %0d exp 0", ferr_cnt10);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat[3];
        pat = '{8'hA5, 8'h00, 8'hFF};
        valid_cyc10.delete();
        for (int i = 0; i < 3; i++) begin
            exp10.push_back(pat[i]);
            send_frame(10, pat[i], 1'b1);
        end
        tick(20);
        wait_drain("b2b_drain", 50);
        total++;
        if (valid_cyc10.size() != 3) begin
            bad++;
            $display("FAIL b2b_pulses got %0d exp 3", valid_cyc10.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (valid_cyc10[i] - valid_cyc10[i-1] != 100) begin
                    bad++;
                    $display("FAIL b2b_spacing got %0d exp 100",
                             valid_cyc10[i] - valid_cyc10[i-1]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int n;
        valid_cyc10.delete();
        line10 = 1'b0;
        tick(3);
        line10 = 1'b1;
        n = 0;
        while (busy10 !== 1'b0 && n < 8) begin
            tick(1);
            n++;
        end
        total += 2;
        if (busy10 !== 1'b0) begin
            bad++;
            $display("FAIL glitch_busy got %b exp 0 within 8 cycles", busy10);
        end
        tick(5);
        if (valid_cyc10.size() != 0 || ferr_cnt10 != 0) begin
            bad++;
            $display("FAIL glitch_pulse got valid=%0d ferr=%0d exp 0", valid_cyc10.size(),
                     ferr_cnt10);
        end
        exp10.push_back(8'h3C);
        send_frame(10, 8'h3C, 1'b1);
        tick(10);
        wait_drain("glitch_next", 50);
    endtask

    task automatic test_frame_err();
        int base;
        valid_cyc10.delete();
        base = ferr_cnt10;
        send_frame(10, 8'h81, 1'b0);
        tick(50);
        total += 4;
        if (ferr_cnt10 - base != 1) begin
            bad++;
            $display("FAIL ferr_count got %0d exp 1", ferr_cnt10 - base);
        end
        if (byte10 !== 8'h3C) begin
            bad++;
            $display("FAIL ferr_hold got %h exp 3c", byte10);
        end
        if (busy10 !== 1'b1) begin
            bad++;
            $display("FAIL ferr_break_busy got %b exp 1", busy10);
        end
        if (valid_cyc10.size() != 0) begin
            bad++;
            $display("FAIL ferr_valid got %0d exp 0", valid_cyc10.size());
        end
        line10 = 1'b1;
        tick(6);
        total++;
        if (busy10 !== 1'b0) begin
            bad++;
            $display("FAIL ferr_release_busy got %b exp 0", busy10);
        end
        exp10.push_back(8'h42);
        send_frame(10, 8'h42, 1'b1);
        tick(10);
        wait_drain("ferr_next", 50);
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] f;
        valid_cyc10.delete();
        f = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            line10 = f[i];
            tick(10);
        end
        line10 = f[5];
        tick(5);
        rst_n = 1'b0;
        #1;
        total += 4;
        if (byte10 !== 8'h00) begin bad++; $display("FAIL mid_rst_byte got %h exp 00", byte10); end
        if (valid10 !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b exp 0", valid10); end
        if (ferr10 !== 1'b0) begin bad++; $display("FAIL mid_rst_ferr got %b exp 0", ferr10); end
        if (busy10 !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %b exp 0", busy10); end
        line10 = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(30);
        total++;
        if (valid_cyc10.size() != 0) begin
            bad++;
            $display("FAIL mid_rst_pulse got %0d exp 0", valid_cyc10.size());
        end
        exp10.push_back(8'h7E);
        send_frame(10, 8'h7E, 1'b1);
        tick(10);
        wait_drain("mid_rst_next", 50);
    endtask

    task automatic test_param_sweep();
        exp4.push_back(8'hB2);
        send_frame(4, 8'hB2, 1'b1);
        tick(8);
        wait_drain("sweep4", 40);
        exp17.push_back(8'hB2);
        send_frame(17, 8'hB2, 1'b1);
        tick(30);
        wait_drain("sweep17", 80);
        total += 2;
        if (byte4 !== 8'hB2) begin bad++; $display("FAIL sweep4_byte got %h exp b2", byte4); end
        if (byte17 !== 8'hB2) begin bad++; $display("FAIL sweep17_byte got %h exp b2", byte17); end
        total++;
        if (ferr_cnt_other != 0) begin
            bad++;
            $display("FAIL sweep_ferr got %0d exp 0", ferr_cnt_other);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
